// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the serial transmit/receive pair: the frame FSM
// state type and the line-level / frame-size constants. The matching
// receiver imports the same package so both ends agree on the framing.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   FRAME_BITS  = 10;
  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx8bit_bit_timer.sv
// bit_timer
// Divides the clock into serial bit cells of DIV cycles each. The count
// runs 0..DIV-1 and wraps on every bit boundary; with DIV=1 every cycle is
// a boundary. Shared between the transmitter and the receiver.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset
//   clear - restart the current bit cell (count back to 0)
//   tick  - high on the last cycle of each bit cell
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= 8'd0;
    end else if (cnt == LAST) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx8bit.sv
// serial_tx8bit
// Parallel-in, serial-out transmitter. Accepts a byte through a
// valid/ready handshake and sends it as start bit, 8 data bits, stop bit,
// each held for DIV clock cycles. done pulses for one cycle in the first
// idle cycle after a complete frame.
//
// Parameters:
//   DIV       - clock cycles per serial bit (1..255)
//   MSB_FIRST - 1: d[0] (the MSB of d[0:7]) goes first; 0: d[7] goes first
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset
//   d     - byte to send, sampled only on accept
//   valid - byte on d is offered
//   ready - idle and able to accept
//   sout  - serial line, idles high
//   busy  - frame in progress
//   done  - one-cycle pulse when a frame has finished
module serial_tx8bit
  import serial_pkg::*;
#(
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] d,
  input  logic       valid,
  output logic       ready,
  output logic       sout,
  output logic       busy,
  output logic       done
);

  tx_state_t  state;
  tx_state_t  state_nxt;
  logic [0:7] shreg;
  logic [2:0] idx;
  logic       tick;
  logic       accept;
  logic       timer_clear;
  logic       done_q;

  // The timer is held at zero while idle so the start bit always gets a
  // full DIV cycles counted from the accept edge.
  assign timer_clear = (state == IDLE);

  bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sout      = IDLE_LEVEL;
    ready     = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (valid) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        sout = START_LEVEL;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        sout = MSB_FIRST ? shreg[0] : shreg[7];
        if (tick && (idx == 3'(DATA_BITS - 1))) state_nxt = STOP;
      end
      STOP: begin
        sout = STOP_LEVEL;
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The outgoing bit always sits at one end of the shift register; the
  // register shifts toward that end once per bit cell.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg  <= 8'h00;
      idx    <= 3'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == STOP) && tick;
      if (accept) begin
        shreg <= d;
        idx   <= 3'd0;
      end else if ((state == DATA) && tick) begin
        if (MSB_FIRST) begin
          shreg <= {shreg[1:7], 1'b0};
        end else begin
          shreg <= {1'b0, shreg[0:6]};
        end
        idx <= idx + 3'd1;
      end
    end
  end

  assign done = done_q;

endmodule
